// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit-side blocks.
package eth_pkg;

    localparam int ETH_MAX_FRAME_LEN = 1522;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } eth_arb_state_t;

endpackage

// File: rtl/eth_tx_frame_arbiter_pick.sv
// Combinational rotate-priority encoder: the first requester after 'last'
// (wrapping) wins, and 'last' itself has the lowest priority.
module eth_rr_pick #(
    parameter int PORTS = 4,
    parameter int IW    = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             any,
    output logic [IW-1:0]    idx
);

    int w_cand;

    // Walk from the lowest to the highest priority so the nearest requester overrides.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = 0;
        for (int k = PORTS; k >= 1; k--) begin
            w_cand = (int'(last) + k) % PORTS;
            if (req[IW'(w_cand)]) begin
                any = 1'b1;
                idx = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter feeding the MAC transmit stream through one
// output register; oversize frames are cut with an error mark and then drained.
module eth_tx_frame_arbiter
    import eth_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int MAX_FRAME_LEN = ETH_MAX_FRAME_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS*8-1:0]       s_axis_tdata,
    input  logic [PORTS-1:0]         s_axis_tvalid,
    output logic [PORTS-1:0]         s_axis_tready,
    input  logic [PORTS-1:0]         s_axis_tlast,
    input  logic [PORTS-1:0]         s_axis_tuser,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic                     enable,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_index,
    output logic                     oversize_pulse
);

    localparam int IW = $clog2(PORTS);
    localparam int CW = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [CW-1:0] TRUNC_CNT = CW'(MAX_FRAME_LEN - 1);

    eth_arb_state_t r_state, w_next;
    logic [IW-1:0]  r_grant, r_last_grant, w_pick_idx;
    logic [CW-1:0]  r_beat_cnt;
    logic [7:0]     r_mdata, w_src_data;
    logic           r_mvalid, r_mlast, r_muser, r_ovs;
    logic           w_pick_any, w_src_valid, w_src_last, w_src_user;
    logic           w_out_free, w_acc, w_load, w_done, w_trunc, w_grant_new;

    eth_rr_pick #(.PORTS(PORTS)) u_pick (
        .req  (s_axis_tvalid),
        .last (r_last_grant),
        .any  (w_pick_any),
        .idx  (w_pick_idx)
    );

    assign w_src_valid = s_axis_tvalid[r_grant];
    assign w_src_last  = s_axis_tlast[r_grant];
    assign w_src_user  = s_axis_tuser[r_grant];
    assign w_src_data  = s_axis_tdata[{r_grant, 3'b000} +: 8];
    assign w_out_free  = m_axis_tready | ~r_mvalid;
    // The beat being accepted is number r_beat_cnt+1; cutting happens only without tlast.
    assign w_trunc     = (r_beat_cnt == TRUNC_CNT) & ~w_src_last;
    assign w_grant_new = (r_state == IDLE) & enable & w_pick_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        s_axis_tready = '0;
        w_acc         = 1'b0;
        w_load        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_new) w_next = XFER;
            end
            XFER: begin
                s_axis_tready[r_grant] = w_out_free;
                w_acc  = w_src_valid & w_out_free;
                w_load = w_acc;
                if (w_acc && w_src_last) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end else if (w_acc && w_trunc) begin
                    w_next = DRAIN;
                    w_done = 1'b1;
                end
            end
            DRAIN: begin
                s_axis_tready[r_grant] = 1'b1;
                w_acc = w_src_valid;
                if (w_acc && w_src_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= IW'(PORTS - 1);
            r_beat_cnt   <= '0;
            r_mdata      <= '0;
            r_mvalid     <= 1'b0;
            r_mlast      <= 1'b0;
            r_muser      <= 1'b0;
            r_ovs        <= 1'b0;
        end else begin
            r_ovs <= w_load & w_trunc;
            if (w_grant_new) begin
                r_grant    <= w_pick_idx;
                r_beat_cnt <= '0;
            end
            if (w_done) r_last_grant <= r_grant;
            if (w_load) begin
                r_beat_cnt <= r_beat_cnt + CW'(1);
                r_mdata    <= w_src_data;
                r_mvalid   <= 1'b1;
                r_mlast    <= w_src_last | w_trunc;
                r_muser    <= w_src_user | w_trunc;
            end else if (m_axis_tready) begin
                r_mvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata   = r_mdata;
    assign m_axis_tvalid  = r_mvalid;
    assign m_axis_tlast   = r_mlast;
    assign m_axis_tuser   = r_muser;
    assign grant_valid    = (r_state != IDLE);
    assign grant_index    = r_grant;
    assign oversize_pulse = r_ovs;

endmodule
